// File: rtl/spaceship_hit_detector_if.sv
// spaceship_hit_detector_if: ship stream, launch controls and game status between player logic and the hit detector.
interface spaceship_hit_detector_if;
    logic [3:0]  ship_state;
    logic        fire;
    logic [3:0]  aim;
    logic        restart;
    logic [15:0] led;
    logic        busy;
    logic        hit_pulse;
    logic        miss_pulse;
    logic [7:0]  score;
    logic [3:0]  misses;
    logic        game_over;
    logic        invalid_state;
    modport master (
        output ship_state, fire, aim, restart,
        input  led, busy, hit_pulse, miss_pulse, score, misses, game_over, invalid_state
    );
    modport slave (
        input  ship_state, fire, aim, restart,
        output led, busy, hit_pulse, miss_pulse, score, misses, game_over, invalid_state
    );
endinterface

// File: rtl/spaceship_hit_detector.sv
// spaceship_hit_detector: decodes ship position onto an LED bar and resolves one missile at a time as hit or miss.
module spaceship_hit_detector #(
    parameter int FLIGHT_CYCLES = 4,
    parameter int MAX_MISSES    = 3
) (
    input logic clk,
    input logic rst_n,
    spaceship_hit_detector_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FLIGHT, GAME_OVER} state_t;
    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx, score_nx;
    logic [3:0]  aim_lat, aim_nx, misses_nx;
    logic        ship_ok, hit_nx, miss_nx;
    logic [15:0] led_nx;
    assign bus.busy      = state == FLIGHT;
    assign bus.game_over = state == GAME_OVER;
    always_comb begin
        ship_ok   = ~bus.ship_state[0] && |bus.ship_state;
        state_nx  = state;
        cnt_nx    = cnt;
        aim_nx    = aim_lat;
        score_nx  = bus.score;
        misses_nx = bus.misses;
        hit_nx    = 1'b0;
        miss_nx   = 1'b0;
        if (bus.restart) begin
            state_nx  = IDLE;
            score_nx  = 8'd0;
            misses_nx = 4'd0;
        end else if (state == IDLE && bus.fire) begin
            state_nx = FLIGHT;
            cnt_nx   = 8'(FLIGHT_CYCLES - 1);
            aim_nx   = bus.aim;
        end else if (state == FLIGHT) begin
            if (cnt != 8'd0) begin
                cnt_nx = cnt - 8'd1;
            end else if (ship_ok && bus.ship_state == aim_lat) begin
                hit_nx   = 1'b1;
                score_nx = (bus.score == 8'hff) ? bus.score : bus.score + 8'd1;
                state_nx = IDLE;
            end else begin
                // an invalid position is always a miss, even if it equals the aim
                miss_nx   = 1'b1;
                misses_nx = bus.misses + 4'd1;
                state_nx  = ({1'b0, bus.misses} + 5'd1 == 5'(MAX_MISSES)) ? GAME_OVER : IDLE;
            end
        end
        led_nx = (ship_ok ? 16'd1 << bus.ship_state : 16'd0)
               | (state_nx == FLIGHT ? 16'd1 << aim_nx : 16'd0);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            cnt               <= 8'd0;
            aim_lat           <= 4'd0;
            bus.led           <= 16'd0;
            bus.score         <= 8'd0;
            bus.misses        <= 4'd0;
            bus.hit_pulse     <= 1'b0;
            bus.miss_pulse    <= 1'b0;
            bus.invalid_state <= 1'b0;
        end else begin
            state             <= state_nx;
            cnt               <= cnt_nx;
            aim_lat           <= aim_nx;
            bus.led           <= led_nx;
            bus.score         <= score_nx;
            bus.misses        <= misses_nx;
            bus.hit_pulse     <= hit_nx;
            bus.miss_pulse    <= miss_nx;
            bus.invalid_state <= ~ship_ok;
        end
    end
endmodule

// File: tb/tb_spaceship_hit_detector.sv
// tb_spaceship_hit_detector: directed vectors checked every cycle against a time-based game model plus literal expectations.
module tb_spaceship_hit_detector;
    localparam int FLIGHT = 4;
    localparam int MAXM   = 3;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total = 0;
    spaceship_hit_detector_if bus ();
    spaceship_hit_detector #(.FLIGHT_CYCLES(FLIGHT), .MAX_MISSES(MAXM)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    endtask
    // model: mode 0 idle, 1 flying, 2 over; a shot launched at edge n resolves at edge n+FLIGHT
    int mode, edge_n, launch, m_aim, m_score, m_miss;
    logic [15:0] m_led;
    bit   m_hit, m_mis, m_inv, ok;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode = 0; edge_n = 0; launch = 0; m_aim = 0; m_score = 0; m_miss = 0;
            m_led = 0; m_hit = 0; m_mis = 0; m_inv = 0;
        end else begin
            edge_n++;
            m_hit = 0; m_mis = 0;
            ok = (bus.ship_state % 2 == 0) && (bus.ship_state != 0);
            if (bus.restart) begin
                mode = 0; m_score = 0; m_miss = 0;
            end else if (mode == 0 && bus.fire) begin
                mode = 1; launch = edge_n; m_aim = bus.aim;
            end else if (mode == 1 && edge_n - launch == FLIGHT) begin
                if (ok && bus.ship_state == m_aim) begin
                    m_hit = 1; m_score = (m_score < 255) ? m_score + 1 : 255; mode = 0;
                end else begin
                    m_mis = 1; m_miss++; mode = (m_miss == MAXM) ? 2 : 0;
                end
            end
            m_led = 0;
            if (ok) m_led[bus.ship_state] = 1'b1;
            if (mode == 1) m_led[m_aim] = 1'b1;
            m_inv = !ok;
            #1;
            check("led", bus.led, m_led);
            check("busy", bus.busy, mode == 1);
            check("hit_pulse", bus.hit_pulse, m_hit);
            check("miss_pulse", bus.miss_pulse, m_mis);
            check("score", bus.score, m_score);
            check("misses", bus.misses, m_miss);
            check("game_over", bus.game_over, mode == 2);
            check("invalid_state", bus.invalid_state, m_inv);
        end
    end
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    initial begin
        bus.ship_state = 4'd2; bus.fire = 1'b0; bus.aim = 4'd0; bus.restart = 1'b0;
        cyc(3);
        check("rst_led", bus.led, 0);
        check("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        // reset mid-flight
        bus.aim = 4'd6; bus.fire = 1'b1;
        cyc(1);
        bus.fire = 1'b0;
        cyc(2);
        check("pre_rst_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_led", bus.led, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_pulses", {bus.hit_pulse, bus.miss_pulse, bus.invalid_state}, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(8);
        // hit with sweeping ship: 12,14,2,4,6 at E0..E4
        bus.ship_state = 4'd12; bus.aim = 4'd6; bus.fire = 1'b1;
        cyc(1);
        bus.fire = 1'b0;
        check("hit_led_e0", bus.led, 16'h1040);
        check("hit_busy_e0", bus.busy, 1);
        bus.ship_state = 4'd14; cyc(1);
        bus.ship_state = 4'd2;  cyc(1);
        bus.ship_state = 4'd4;  cyc(1);
        check("hit_busy_e3", bus.busy, 1);
        check("hit_nopulse_e3", bus.hit_pulse, 0);
        bus.ship_state = 4'd6;  cyc(1);
        check("hit_pulse_e4", bus.hit_pulse, 1);
        check("hit_score", bus.score, 1);
        check("hit_busy_after", bus.busy, 0);
        // invalid position, then overlay of ship and missile on one bit
        bus.ship_state = 4'd5; cyc(1);
        check("inv_flag", bus.invalid_state, 1);
        check("inv_led", bus.led, 0);
        bus.ship_state = 4'd8; bus.aim = 4'd8; bus.fire = 1'b1; cyc(1);
        bus.fire = 1'b0;
        check("overlay_led", bus.led, 16'h0100);
        cyc(6);
        check("overlay_score", bus.score, 2);
        // three misses end the game; aim 3 can never be a valid ship position
        bus.ship_state = 4'd3; bus.aim = 4'd3; bus.fire = 1'b1;
        cyc(20);
        check("go_misses", bus.misses, 3);
        check("go_flag", bus.game_over, 1);
        check("go_busy", bus.busy, 0);
        check("go_score_held", bus.score, 2);
        bus.fire = 1'b0; bus.restart = 1'b1; cyc(1);
        bus.restart = 1'b0;
        check("rs_go", bus.game_over, 0);
        check("rs_score", bus.score, 0);
        check("rs_misses", bus.misses, 0);
        bus.ship_state = 4'd6; bus.aim = 4'd6; bus.fire = 1'b1; cyc(1);
        check("rs_fire_busy", bus.busy, 1);
        // saturation: keep firing back to back at a stationary ship
        cyc(265 * (FLIGHT + 1));
        bus.fire = 1'b0;
        cyc(FLIGHT + 2);
        check("sat_score", bus.score, 255);
        // restart on the resolution edge wins over the hit
        bus.fire = 1'b1; cyc(1);
        bus.fire = 1'b0; cyc(FLIGHT - 1);
        bus.restart = 1'b1; cyc(1);
        bus.restart = 1'b0;
        check("rs_cnt0_hit", bus.hit_pulse, 0);
        check("rs_cnt0_score", bus.score, 0);
        cyc(3);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/spaceship_hit_detector.md
Name: spaceship_hit_detector

Overview:
Consumer end of the spaceship position stream. Takes the 4-bit ship position produced by the ship LED state generator (even values 2..14, stepping by 2 and wrapping 14->2) and decodes it onto a 16-LED bar. It also runs one missile at a time: the missile is fired at a player-chosen column, flies for a fixed time, and is then resolved as hit or miss against the live ship position. It keeps score and miss count and stops the game after too many misses.

Parameters:
FLIGHT_CYCLES, 4, missile flight time in clock cycles; legal range 1..255.
MAX_MISSES, 3, miss count that ends the game; legal range 1..15.

Ports:
Clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
ship_state  in  4  ship position; valid only if even and nonzero (2,4,...,14)
fire  in  1  level-sampled launch request
aim  in  4  target column, latched when a launch is accepted
restart  in  1  clear score and misses, return to IDLE
led  out  16  registered LED pattern
busy  out  1  high while state is FLIGHT
hit_pulse  out  1  one-cycle pulse on a hit
miss_pulse  out  1  one-cycle pulse on a miss
score  out  8  hit count, saturates at 255
misses  out  4  miss count
game_over  out  1  high in GAME_OVER
invalid_state  out  1  registered; high the cycle after a sampled ship_state is odd or 0

Behaviour:
- rst low: state=IDLE; led, score, misses, aim_lat and flight counter = 0; busy, hit_pulse, miss_pulse, game_over, invalid_state = 0. Takes effect immediately with no clock edge, including mid-flight.
- States: IDLE, FLIGHT, GAME_OVER.
- IDLE, fire=1 at edge E0: aim_lat<=aim, cnt<=FLIGHT_CYCLES-1, state<=FLIGHT.
- FLIGHT, cnt!=0: cnt decrements each edge. fire is ignored; there is no queueing.
- FLIGHT, cnt==0 at edge: compare ship_state sampled at that edge with aim_lat.
  - Equal and ship_state valid: hit_pulse<=1, score<=score+1 (saturating), state<=IDLE.
  - Otherwise: miss_pulse<=1, misses<=misses+1.
  - If misses+1 == MAX_MISSES: state<=GAME_OVER; else state<=IDLE.
- Resolution timing: fire sampled at E0 -> pulse high for exactly one cycle after edge E(FLIGHT_CYCLES).
- hit_pulse and miss_pulse are never both high.
- An invalid ship_state at resolution is always a miss, even if it equals aim_lat.
- GAME_OVER: game_over=1; fire is ignored; score and misses are held.
- restart=1 at an edge, in any state: score<=0, misses<=0, state<=IDLE, no pulse.
  - Aborts a flight in progress, including one with cnt==0.
  - Has priority over fire and over resolution.
- busy is combinational from state (high exactly in FLIGHT).
- led, registered every edge:
  - led[ship_state]=1 if ship_state is valid.
  - Also led[aim_lat]=1 while the next state is FLIGHT.
  - All other bits 0.
  - Ship bit and missile bit may coincide (single bit set).
- invalid_state is registered, same latency as led. No other effect besides forcing a miss at resolution.
- Back-to-back launches: fire held high -> relaunch at the first edge after return to IDLE. The fire level is re-sampled; no edge detect.

Test Plan:
- Reset mid-flight: fire aim=6 at E0, assert rst low during FLIGHT -> all outputs 0 immediately; no pulse after rst released.
- Hit: defaults, ship_state sweeping 2,4,...,14 with ship_state=6 at E4, fire aim=6 at E0 -> hit_pulse only in cycle after E4; score=1; busy high E0..E4; led[6] set during flight.
- Miss to game over: three launches with aim=3 (never valid) -> three miss_pulses; misses=3; game_over=1; a further fire gives no busy.
- Restart: from GAME_OVER with score=2, restart=1 -> next cycle state IDLE, score=0, misses=0, game_over=0; fire then accepted.
- Invalid and overlay: ship_state=5 -> invalid_state=1 next cycle and no ship LED; ship_state=8 with aim_lat=8 in flight -> led=16'h0100.
- Saturation and simultaneity: preload 255 hits -> further hit keeps score=255. restart and cnt==0 on the same edge -> no pulse, score=0.
